// File: rtl/alarm_pkg.sv
// Shared types and BCD helpers for the alarm controller.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package alarm_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RINGING,
    SNOOZE
  } alarm_state_t;

  // Two-digit BCD roll-over points for the alarm hour and minute fields.
  localparam logic [7:0] HOUR_LIMIT = 8'h23;
  localparam logic [7:0] MIN_LIMIT  = 8'h59;

  // Increment a two-digit BCD value, wrapping to 00 after the limit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] limit);
    if (v == limit) begin
      return 8'h00;
    end
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/alarm_controller_tone_gen.sv
// Buzzer square-wave generator: toggles every TONE_DIV cycles while enabled.
// Latency: first rising edge of tone TONE_DIV cycles after enable rises.
// Backpressure: none; enable=0 clears the divider and holds tone low.
module tone_gen #(
  parameter int TONE_DIV = 4
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  output logic tone
);

  localparam int CW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  logic [CW-1:0] div_cnt;

  // Divide the clock down to a half-period of TONE_DIV cycles; restart from 0 when disabled.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tone    <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      tone    <= 1'b0;
    end else if (div_cnt == CW'(TONE_DIV - 1)) begin
      div_cnt <= '0;
      tone    <= ~tone;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: stores the BCD alarm time, detects a match against the running time and sequences ring/snooze/stop.
// Latency: ringing/armed are registered, one clk_in edge after the causing event; buzzer drops in the same cycle ringing does.
// Backpressure: none; ALARM_SNOOZE_EN enables the SNOOZE state, otherwise the snooze input is ignored.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int TONE_DIV       = 4,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int RESET_HOUR     = 7
) (
  input  logic clk_in,
  input  logic reset,
  input  logic sec_tick,
  input  bcd_t hour_high,
  input  bcd_t hour_low,
  input  bcd_t min_high,
  input  bcd_t min_low,
  input  logic alarm_enable,
  input  logic set_hour,
  input  logic set_min,
  input  logic snooze,
  input  logic stop,
  output bcd_t alarm_hh,
  output bcd_t alarm_hl,
  output bcd_t alarm_mh,
  output bcd_t alarm_ml,
  output logic armed,
  output logic ringing,
  output logic buzzer
);

  localparam int RCW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
  localparam logic [7:0] RESET_HOUR_BCD = {4'(RESET_HOUR / 10), 4'(RESET_HOUR % 10)};

  alarm_state_t   state;
  alarm_state_t   state_nxt;
  logic [7:0]     alarm_h;
  logic [7:0]     alarm_m;
  logic           match;
  logic           match_q;
  logic           match_evt;
  logic [RCW-1:0] ring_cnt;
  logic           ring_done;
  logic           tone;

`ifdef ALARM_SNOOZE_EN
  localparam int SCW = (SNOOZE_SECONDS > 1) ? $clog2(SNOOZE_SECONDS) : 1;
  logic [SCW-1:0] snz_cnt;
  logic           snz_done;
  assign snz_done = sec_tick && (snz_cnt == SCW'(SNOOZE_SECONDS - 1));
`else
  localparam int unused_snooze_seconds = SNOOZE_SECONDS;
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // A match only fires on its first cycle, so a whole minute of equality rings once.
  assign match     = ({hour_high, hour_low, min_high, min_low} == {alarm_h, alarm_m});
  assign match_evt = match & ~match_q;
  assign ring_done = sec_tick && (ring_cnt == RCW'(RING_SECONDS - 1));

  // Next-state selection: disable beats stop, stop beats snooze, snooze beats timers and match.
  always_comb begin
    state_nxt = state;
    if (!alarm_enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARMED;
        ARMED:   if (match_evt) state_nxt = RINGING;
        RINGING: begin
          if (stop) state_nxt = ARMED;
`ifdef ALARM_SNOOZE_EN
          else if (snooze) state_nxt = SNOOZE;
`endif
          else if (ring_done) state_nxt = ARMED;
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop) state_nxt = ARMED;
          else if (snz_done) state_nxt = RINGING;
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state, registered status outputs, match history and ring/snooze second counters.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      armed    <= 1'b0;
      ringing  <= 1'b0;
      match_q  <= 1'b1;
      ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt  <= '0;
`endif
    end else begin
      state   <= state_nxt;
      armed   <= (state_nxt != IDLE);
      ringing <= (state_nxt == RINGING);
      match_q <= match;
      if (state_nxt == RINGING && state != RINGING) begin
        ring_cnt <= '0;
      end else if (state == RINGING && sec_tick) begin
        ring_cnt <= ring_cnt + 1'b1;
      end
`ifdef ALARM_SNOOZE_EN
      if (state_nxt == SNOOZE && state != SNOOZE) begin
        snz_cnt <= '0;
      end else if (state == SNOOZE && sec_tick) begin
        snz_cnt <= snz_cnt + 1'b1;
      end
`endif
    end
  end

  // Alarm time editing; legal in every state and independent of the FSM.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      alarm_h <= RESET_HOUR_BCD;
      alarm_m <= 8'h00;
    end else begin
      if (set_hour) alarm_h <= bcd_inc(alarm_h, HOUR_LIMIT);
      if (set_min)  alarm_m <= bcd_inc(alarm_m, MIN_LIMIT);
    end
  end

  tone_gen #(
    .TONE_DIV(TONE_DIV)
  ) u_tone_gen (
    .clk_in (clk_in),
    .reset  (reset),
    .enable (ringing),
    .tone   (tone)
  );

  // Gating with ringing kills the tone in the very cycle the state leaves RINGING.
  assign buzzer   = tone & ringing;
  assign alarm_hh = alarm_h[7:4];
  assign alarm_hl = alarm_h[3:0];
  assign alarm_mh = alarm_m[7:4];
  assign alarm_ml = alarm_m[3:0];

endmodule
